// File: rtl/noc_pkg.sv
// noc: shared flit-kind encoding and port indices for the 5-port mesh router
package noc;
    localparam int kNumPorts = 5;
    localparam int kPortN = 0;
    localparam int kPortS = 1;
    localparam int kPortW = 2;
    localparam int kPortE = 3;
    localparam int kPortP = 4;
    typedef enum logic [1:0] {
        kFlitBody   = 2'b00,
        kFlitTail   = 2'b01,
        kFlitHead   = 2'b10,
        kFlitSingle = 2'b11
    } flit_kind_t;
    // Head and single-flit kinds both open a packet; tail and single both close one.
    function automatic logic opens_packet(input flit_kind_t k);
        return k == kFlitHead || k == kFlitSingle;
    endfunction
    function automatic logic closes_packet(input flit_kind_t k);
        return k == kFlitTail || k == kFlitSingle;
    endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: round-robin pick of the first candidate at or after ptr
module rr_picker #(
    parameter int PORTS = 5,
    parameter int IDX_W = 3
) (
    input  logic [PORTS-1:0] cand,
    input  logic [IDX_W-1:0] ptr,
    output logic [PORTS-1:0] pick,
    output logic [IDX_W-1:0] pick_idx,
    output logic             any
);
    logic [PORTS-1:0] rot;
    // Rotating the doubled vector right by ptr puts the search start at bit 0.
    assign rot = PORTS'({cand, cand} >> ptr);
    // Priority-encode the rotated vector, then map the offset back to a port index.
    always_comb begin
        pick = '0;
        pick_idx = '0;
        any = 1'b0;
        for (int i = PORTS - 1; i >= 0; i--) begin
            if (rot[i]) begin
                any = 1'b1;
                pick_idx = IDX_W'((int'(ptr) + i) % PORTS);
            end
        end
        if (any) pick[pick_idx] = 1'b1;
    end
endmodule

// File: rtl/wormhole_output_arbiter.sv
// wormhole_output_arbiter: round-robin output-port scheduler that locks a grant for a whole packet
module wormhole_output_arbiter
    import noc::*;
#(
    parameter int PORTS = kNumPorts,
    parameter int IDX_W = 3,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PORTS-1:0]   req,
    input  logic [2*PORTS-1:0] flit_kind,
    input  logic               stop_in,
    output logic [PORTS-1:0]   grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               busy,
    output logic               xfer,
    output logic [PORTS-1:0]   pop,
    output logic [CNT_W-1:0]   flit_count
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t           state, state_n;
    logic [PORTS-1:0] grant_n, cand, pick;
    logic [IDX_W-1:0] idx_n, ptr, ptr_n, pick_idx;
    logic [CNT_W-1:0] cnt_n;
    logic             any;
    flit_kind_t       cur_kind;
    // Only flits that open a packet may win arbitration.
    always_comb begin
        cand = '0;
        for (int i = 0; i < PORTS; i++) cand[i] = req[i] & opens_packet(flit_kind_t'(flit_kind[2*i +: 2]));
    end
    rr_picker #(.PORTS(PORTS), .IDX_W(IDX_W)) u_pick (
        .cand     (cand),
        .ptr      (ptr),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (any)
    );
    assign cur_kind = flit_kind_t'(flit_kind[2*int'(grant_idx) +: 2]);
    assign busy     = state == LOCKED;
    assign xfer     = busy & req[grant_idx] & ~stop_in;
    assign pop      = grant & {PORTS{xfer}};
    // Next-state: grant a new packet from IDLE, count flits and release on the closing flit.
    always_comb begin
        state_n = state;
        grant_n = grant;
        idx_n = grant_idx;
        cnt_n = flit_count;
        ptr_n = ptr;
        if (state == IDLE) begin
            if (any) begin
                state_n = LOCKED;
                grant_n = pick;
                idx_n = pick_idx;
                cnt_n = '0;
            end
        end else if (xfer) begin
            cnt_n = (&flit_count) ? flit_count : flit_count + 1'b1;
            if (closes_packet(cur_kind)) begin
                state_n = IDLE;
                grant_n = '0;
                idx_n = '0;
                ptr_n = (int'(grant_idx) == PORTS - 1) ? '0 : grant_idx + 1'b1;
            end
        end
    end
    // State register with synchronous active-low reset; reset aborts any lock.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            grant <= '0;
            grant_idx <= '0;
            flit_count <= '0;
            ptr <= '0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            grant_idx <= idx_n;
            flit_count <= cnt_n;
            ptr <= ptr_n;
        end
    end
endmodule

// File: tb/tb_wormhole_output_arbiter.sv
// tb_wormhole_output_arbiter: table-driven cycle vectors checked through a scoreboard queue
module tb_wormhole_output_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] req = '0;
    logic [9:0] flit_kind = '0;
    logic       stop_in = 1'b0;
    logic [4:0] grant, pop;
    logic [2:0] grant_idx;
    logic       busy, xfer;
    logic [7:0] flit_count;

    wormhole_output_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .flit_kind  (flit_kind),
        .stop_in    (stop_in),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .busy       (busy),
        .xfer       (xfer),
        .pop        (pop),
        .flit_count (flit_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [4:0] req;
        logic [9:0] kind;
        logic       stop;
        logic [4:0] g;
        logic       x;
        logic [7:0] c;
    } vec_t;

    localparam logic [1:0] H = 2'b10, B = 2'b00, T = 2'b01, S = 2'b11;
    localparam logic [9:0] ALL_H = 10'h2AA, ALL_S = 10'h3FF;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic logic [9:0] kv(int i, logic [1:0] k);
        logic [9:0] v = '0;
        v[2*i +: 2] = k;
        return v;
    endfunction

    function automatic logic [2:0] oh2i(logic [4:0] oh);
        logic [2:0] r = '0;
        for (int i = 0; i < 5; i++) if (oh[i]) r = 3'(i);
        return r;
    endfunction

    task automatic add(logic r, logic [4:0] q, logic [9:0] k, logic s, logic [4:0] g, logic x, logic [7:0] c);
        tbl.push_back('{rst: r, req: q, kind: k, stop: s, g: g, x: x, c: c});
    endtask

    task automatic chk(string name, int row, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL row %0d %s: got %0h expected %0h", row, name, act, exp);
        end
    endtask

    initial begin
        vec_t e;
        // reset held with all inputs requesting heads
        add(0, 5'h1f, ALL_H, 0, 5'b00000, 0, 0);
        add(0, 5'h1f, ALL_H, 0, 5'b00000, 0, 0);
        add(0, 5'h1f, ALL_H, 0, 5'b00000, 0, 0);
        add(1, 5'h1f, ALL_H, 0, 5'b00000, 0, 0);
        add(1, 5'b00001, ALL_S, 0, 5'b00001, 1, 0);
        add(1, 5'b00000, 10'h0, 0, 5'b00000, 0, 1);
        // 7-flit packet on input 4
        add(1, 5'b10000, kv(4, H), 0, 5'b00000, 0, 1);
        add(1, 5'b10000, kv(4, H), 0, 5'b10000, 1, 0);
        for (int i = 1; i <= 5; i++) add(1, 5'b10000, kv(4, B), 0, 5'b10000, 1, 8'(i));
        add(1, 5'b10000, kv(4, T), 0, 5'b10000, 1, 6);
        add(1, 5'b00000, 10'h0, 0, 5'b00000, 0, 7);
        // heads on 0 and 4: ptr wrapped to 0 picks input 0
        add(1, 5'b10001, kv(0, H) | kv(4, H), 0, 5'b00000, 0, 7);
        add(1, 5'b10001, kv(0, S) | kv(4, H), 0, 5'b00001, 1, 0);
        add(1, 5'b00000, 10'h0, 0, 5'b00000, 0, 1);
        // round robin between inputs 1 and 3 with single-flit packets
        for (int i = 0; i < 2; i++) begin
            add(1, 5'b01010, ALL_S, 0, 5'b00000, 0, 1);
            add(1, 5'b01010, ALL_S, 0, 5'b00010, 1, 0);
            add(1, 5'b01010, ALL_S, 0, 5'b00000, 0, 1);
            add(1, 5'b01010, ALL_S, 0, 5'b01000, 1, 0);
        end
        add(1, 5'b00000, 10'h0, 0, 5'b00000, 0, 1);
        // back-pressure mid-packet on input 2, plus an input bubble
        add(1, 5'b00100, kv(2, H), 0, 5'b00000, 0, 1);
        add(1, 5'b00100, kv(2, H), 0, 5'b00100, 1, 0);
        add(1, 5'b00100, kv(2, B), 0, 5'b00100, 1, 1);
        for (int i = 0; i < 4; i++) add(1, 5'b00100, kv(2, B), 1, 5'b00100, 0, 2);
        add(1, 5'b00100, kv(2, B), 0, 5'b00100, 1, 2);
        add(1, 5'b00000, 10'h0, 0, 5'b00100, 0, 3);
        add(1, 5'b00100, kv(2, T), 1, 5'b00100, 0, 3);
        add(1, 5'b00100, kv(2, T), 0, 5'b00100, 1, 3);
        add(1, 5'b00000, 10'h0, 0, 5'b00000, 0, 4);
        // lock on input 0 ignores a competing head on input 3 and a stray head on 0
        add(1, 5'b00001, kv(0, H), 0, 5'b00000, 0, 4);
        add(1, 5'b00001, kv(0, H), 0, 5'b00001, 1, 0);
        add(1, 5'b01001, kv(0, B) | kv(3, H), 0, 5'b00001, 1, 1);
        add(1, 5'b01001, kv(0, B) | kv(3, H), 0, 5'b00001, 1, 2);
        add(1, 5'b01001, kv(0, H) | kv(3, H), 0, 5'b00001, 1, 3);
        add(1, 5'b01001, kv(0, T) | kv(3, H), 0, 5'b00001, 1, 4);
        add(1, 5'b01000, kv(3, H), 0, 5'b00000, 0, 5);
        add(1, 5'b01000, kv(3, S), 0, 5'b01000, 1, 0);
        add(1, 5'b00000, 10'h0, 0, 5'b00000, 0, 1);
        // reset after 3 flits of a packet on input 1
        add(1, 5'b00010, kv(1, H), 0, 5'b00000, 0, 1);
        add(1, 5'b00010, kv(1, H), 0, 5'b00010, 1, 0);
        add(1, 5'b00010, kv(1, B), 0, 5'b00010, 1, 1);
        add(1, 5'b00010, kv(1, B), 0, 5'b00010, 1, 2);
        add(0, 5'b00010, kv(1, B), 0, 5'b00010, 1, 3);
        for (int i = 0; i < 3; i++) add(1, 5'b00001, kv(0, B), 0, 5'b00000, 0, 0);
        // ptr back at 0: heads on 0 and 4 pick input 0
        add(1, 5'b10001, kv(0, H) | kv(4, H), 0, 5'b00000, 0, 0);
        add(1, 5'b10001, kv(0, S) | kv(4, H), 0, 5'b00001, 1, 0);
        add(1, 5'b00000, 10'h0, 0, 5'b00000, 0, 1);

        repeat (2) @(posedge clk);
        foreach (tbl[r]) begin
            @(posedge clk);
            #1;
            rst = tbl[r].rst;
            req = tbl[r].req;
            flit_kind = tbl[r].kind;
            stop_in = tbl[r].stop;
            sb.push_back(tbl[r]);
            @(negedge clk);
            e = sb.pop_front();
            chk("grant", r, 32'(grant), 32'(e.g));
            chk("grant_idx", r, 32'(grant_idx), 32'(oh2i(e.g)));
            chk("busy", r, 32'(busy), 32'(e.g != 0));
            chk("xfer", r, 32'(xfer), 32'(e.x));
            chk("pop", r, 32'(pop), 32'(e.g & {5{e.x}}));
            chk("flit_count", r, 32'(flit_count), 32'(e.c));
        end
        chk("scoreboard_empty", -1, 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wormhole_output_arbiter.md
Name: wormhole_output_arbiter

Overview:
- Per-output-port scheduler for the 5-port mesh router.
- Shares one output port (N/S/W/E/P) between the input ports whose route-computed destination is that port.
- Grants round-robin on head flits and locks the grant for the whole wormhole packet until its tail flit transfers.
- One instance per output port. It drives the crossbar select and gates the input FIFO pop using the output stop/ack-nack back-pressure.

Parameters:
PORTS, 5, number of competing input ports (N,S,W,E,P order, index 0..4)
IDX_W, 3, width of grant_idx, must satisfy 2**IDX_W >= PORTS
CNT_W, 8, width of the per-packet flit counter (saturating)

Ports:
clk  in  1  router clock
rst  in  1  reset
req  in  PORTS  input i holds a non-void flit routed to this output
flit_kind  in  PORTS*2  2-bit kind of the flit at the head of input i (bits 33:32 of the flit): 10 head, 00 body, 01 tail, 11 single-flit packet
stop_in  in  1  downstream stop for this output; 1 = no transfer this cycle
grant  out  PORTS  one-hot grant, registered
grant_idx  out  IDX_W  binary index of the granted input, 0 when grant==0
busy  out  1  packet locked on this output
xfer  out  1  flit moves this cycle (combinational): busy & req[grant_idx] & !stop_in
pop  out  PORTS  one-hot FIFO pop to the granted input, equal to grant & {PORTS{xfer}}
flit_count  out  CNT_W  flits transferred in the current packet, saturating at all-ones

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-low.
- Reset values: state=IDLE, grant=0, grant_idx=0, busy=0, flit_count=0, priority pointer ptr=0. Reset asserted mid-packet aborts the lock with no tail required.
- State IDLE:
  - Candidates: req[i] & (flit_kind[i]==10 or 11).
  - Pick the first candidate at or after ptr, wrapping from PORTS-1 to 0.
  - If a candidate exists, next cycle: state=LOCKED, grant=onehot(pick), busy=1, flit_count=0.
  - Otherwise stay in IDLE.
  - Body or tail flits presented in IDLE are ignored and never granted.
- Arbitration latency: request at edge n produces a grant visible after edge n+1. The first flit can transfer in the cycle following the edge that sets grant.
- State LOCKED:
  - Each cycle with xfer=1: flit_count++ (saturating).
  - If the transferred flit_kind is 01 or 11: next state=IDLE, grant=0, busy=0, ptr=(grant_idx+1) mod PORTS.
  - xfer=0 (req low: input bubble; or stop_in=1) holds all state. The lock never times out.
  - Requests from other inputs are ignored while LOCKED, including new heads.
- Idle gap: one idle cycle follows every tail before the next grant, so the sustained cost is one bubble per packet.
- Simultaneous events:
  - Tail xfer and a new head on another input in the same cycle: the new head is evaluated in the following IDLE cycle using the updated ptr.
  - stop_in=1 on the tail cycle: no release; retried next cycle.
- Protocol error: a head flit (10) arriving on the granted input while LOCKED is transferred as an ordinary flit. No release occurs, and the lock persists until a tail arrives.
- ptr update: changes only on release. Wrap: grant_idx=PORTS-1 gives ptr=0.
- Invariant: grant is always one-hot or zero, and busy == (grant != 0).

Decomposition:
- Package noc:
  - typedef enum logic [1:0] flit_kind_t {kFlitBody=2'b00, kFlitTail=2'b01, kFlitHead=2'b10, kFlitSingle=2'b11}
  - kPortN..kPortP index constants
  - kNumPorts=5
- Sub-module rr_picker: purely combinational.
  - Inputs: cand[PORTS], ptr.
  - Outputs: pick one-hot, pick_idx, any.
  - Implemented with the double-width mask/priority-encode method.
- The FSM, counter and ptr live in wormhole_output_arbiter.

Test Plan:
1. Reset: rst=0 for 3 cycles with req=5'h1f, all heads -> grant=0, busy=0, ptr=0. After release, grant=5'b00001 one cycle later.
2. 7-flit packet on P: head, 5 bodies, tail on input 4 (stop_in=0) -> grant=5'b10000 and 7 consecutive xfer. flit_count reaches 7. After the tail edge, busy=0 and ptr=0 (wrap from 4).
3. Round-robin: heads on inputs 1 and 3 simultaneously, single-flit (11) each, always re-requesting -> grant sequence 1,3,1,3 with one idle cycle between grants.
4. Back-pressure: stop_in=1 for 4 cycles mid-packet on input 2 -> xfer=0 and pop=0, flit_count frozen, grant held. The packet resumes and completes when stop_in returns to 0.
5. Lock protection: input 0 locked, a head appears on input 3 mid-packet -> input 3 is not granted until the cycle after input 0's tail transfers, then grant=5'b01000.
6. Reset mid-packet: assert rst after 3 of 7 flits -> next cycle grant=0, flit_count=0, ptr=0. A stray body flit on input 0 after reset is never granted.
